// File: rtl/control_unit.sv
// Main decode/control unit for the WISC-S25 single-cycle CPU.
// Opcode decode is purely combinational; the only state is the sticky halted flag.
module control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instruction,
    output logic        RR1Mux,
    output logic        RR2Mux,
    output logic [1:0]  ImmMux,
    output logic        ALUSrcMux,
    output logic        MemtoRegMux,
    output logic        PCSMux,
    output logic        HaltMux,
    output logic        BranchRegMux,
    output logic        BranchMux,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        DataMemEnable,
    output logic        halted
);

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [1:0] IMM_SHIFT = 2'b00;
    localparam logic [1:0] IMM_MEM   = 2'b01;
    localparam logic [1:0] IMM_BYTE  = 2'b10;

    logic [3:0] opcode;
    logic       reg_write_raw;
    logic       mem_write_raw;
    logic       mem_enable_raw;
    logic       branch_raw;
    logic       branch_reg_raw;
    logic       pcs_raw;
    logic       unused_operand;

    assign opcode         = instruction[15:12];
    assign unused_operand = ^instruction[11:0];

    // Opcode decode; anything not set for an opcode stays at 0.
    always_comb begin
        RR1Mux         = 1'b0;
        RR2Mux         = 1'b0;
        ImmMux         = IMM_SHIFT;
        ALUSrcMux      = 1'b0;
        MemtoRegMux    = 1'b0;
        HaltMux        = 1'b0;
        pcs_raw        = 1'b0;
        branch_raw     = 1'b0;
        branch_reg_raw = 1'b0;
        reg_write_raw  = 1'b0;
        mem_write_raw  = 1'b0;
        mem_enable_raw = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                reg_write_raw = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                ImmMux        = IMM_SHIFT;
                ALUSrcMux     = 1'b1;
                reg_write_raw = 1'b1;
            end
            OP_LW: begin
                ImmMux         = IMM_MEM;
                ALUSrcMux      = 1'b1;
                MemtoRegMux    = 1'b1;
                reg_write_raw  = 1'b1;
                mem_enable_raw = 1'b1;
            end
            OP_SW: begin
                RR2Mux         = 1'b1;
                ImmMux         = IMM_MEM;
                ALUSrcMux      = 1'b1;
                mem_write_raw  = 1'b1;
                mem_enable_raw = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                RR1Mux        = 1'b1;
                ImmMux        = IMM_BYTE;
                ALUSrcMux     = 1'b1;
                reg_write_raw = 1'b1;
            end
            OP_B: begin
                branch_raw = 1'b1;
            end
            OP_BR: begin
                branch_reg_raw = 1'b1;
            end
            OP_PCS: begin
                pcs_raw       = 1'b1;
                reg_write_raw = 1'b1;
            end
            OP_HLT: begin
                HaltMux = 1'b1;
            end
            default: begin
                HaltMux = 1'b0;
            end
        endcase
    end

    // Once halted, suppress every architectural side effect.
    always_comb begin
        RegWrite      = reg_write_raw  & ~halted;
        MemWrite      = mem_write_raw  & ~halted;
        DataMemEnable = mem_enable_raw & ~halted;
        BranchMux     = branch_raw     & ~halted;
        BranchRegMux  = branch_reg_raw & ~halted;
        PCSMux        = pcs_raw        & ~halted;
    end

    // Sticky halt flag; reset wins over a simultaneous HLT.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted <= 1'b0;
        end else if (HaltMux) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes hand-computed expectations,
// a monitor on the falling edge pops and compares against the DUT outputs.
module tb_control_unit;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic        RR1Mux, RR2Mux, ALUSrcMux, MemtoRegMux, PCSMux, HaltMux;
    logic        BranchRegMux, BranchMux, RegWrite, MemWrite, DataMemEnable, halted;
    logic [1:0]  ImmMux;

    control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .RR1Mux       (RR1Mux),
        .RR2Mux       (RR2Mux),
        .ImmMux       (ImmMux),
        .ALUSrcMux    (ALUSrcMux),
        .MemtoRegMux  (MemtoRegMux),
        .PCSMux       (PCSMux),
        .HaltMux      (HaltMux),
        .BranchRegMux (BranchRegMux),
        .BranchMux    (BranchMux),
        .RegWrite     (RegWrite),
        .MemWrite     (MemWrite),
        .DataMemEnable(DataMemEnable),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: RR1 RR2 Imm[1:0] ALUSrc MemtoReg PCS Halt BrReg Br RegWr MemWr DMEn halted
    logic [13:0] exp_q [$];
    logic [15:0] ins_q [$];
    int          vectors;
    int          miscompares;

    logic [13:0] actual;
    assign actual = {RR1Mux, RR2Mux, ImmMux, ALUSrcMux, MemtoRegMux, PCSMux, HaltMux,
                     BranchRegMux, BranchMux, RegWrite, MemWrite, DataMemEnable, halted};

    // Monitor: one comparison per outstanding expectation, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            logic [15:0] ins;
            e   = exp_q.pop_front();
            ins = ins_q.pop_front();
            vectors++;
            if (actual !== e) begin
                miscompares++;
                $display("FAIL decode instr=%04h rst=%0b: got %014b expected %014b",
                         ins, rst, actual, e);
            end
        end
    end

    task automatic apply(input logic [15:0] ins, input logic r, input logic [13:0] e);
        @(posedge clk);
        #1;
        instruction = ins;
        rst         = r;
        exp_q.push_back(e);
        ins_q.push_back(ins);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        instruction = 16'h0000;
        @(posedge clk);

        // Reset cycle; decode still follows instruction.
        apply(16'h0000, 1'b1, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        // Every opcode with zero operand field.
        apply(16'h1000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        apply(16'h2000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        apply(16'h3000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        apply(16'h4000, 1'b0, 14'b0_0_00_1_0_0_0_0_0_1_0_0_0);
        apply(16'h5000, 1'b0, 14'b0_0_00_1_0_0_0_0_0_1_0_0_0);
        apply(16'h6000, 1'b0, 14'b0_0_00_1_0_0_0_0_0_1_0_0_0);
        apply(16'h7000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        apply(16'h8000, 1'b0, 14'b0_0_01_1_1_0_0_0_0_1_0_1_0);
        apply(16'h9000, 1'b0, 14'b0_1_01_1_0_0_0_0_0_0_1_1_0);
        apply(16'hA000, 1'b0, 14'b1_0_10_1_0_0_0_0_0_1_0_0_0);
        apply(16'hB000, 1'b0, 14'b1_0_10_1_0_0_0_0_0_1_0_0_0);
        apply(16'hC000, 1'b0, 14'b0_0_00_0_0_0_0_0_1_0_0_0_0);
        apply(16'hD000, 1'b0, 14'b0_0_00_0_0_0_0_1_0_0_0_0_0);
        apply(16'hE000, 1'b0, 14'b0_0_00_0_0_1_0_0_0_1_0_0_0);
        // Low 12 bits must not matter.
        apply(16'h9ABC, 1'b0, 14'b0_1_01_1_0_0_0_0_0_0_1_1_0);
        apply(16'hA5FF, 1'b0, 14'b1_0_10_1_0_0_0_0_0_1_0_0_0);
        apply(16'h0FFF, 1'b0, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        apply(16'h4321, 1'b0, 14'b0_0_00_1_0_0_0_0_0_1_0_0_0);
        // HLT: flag sets at the following edge, then gates side effects.
        apply(16'hF000, 1'b0, 14'b0_0_00_0_0_0_1_0_0_0_0_0_0);
        apply(16'h0000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_0_0_0_1);
        apply(16'h8000, 1'b0, 14'b0_0_01_1_1_0_0_0_0_0_0_0_1);
        apply(16'h9000, 1'b0, 14'b0_1_01_1_0_0_0_0_0_0_0_0_1);
        apply(16'hC000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_0_0_0_1);
        apply(16'hD000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_0_0_0_1);
        apply(16'hE000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_0_0_0_1);
        apply(16'hF000, 1'b0, 14'b0_0_00_0_0_0_1_0_0_0_0_0_1);
        // Reset clears the flag at the next edge.
        apply(16'h0000, 1'b1, 14'b0_0_00_0_0_0_0_0_0_0_0_0_1);
        apply(16'h0000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        // Reset and HLT at the same edge: reset wins.
        apply(16'hF000, 1'b1, 14'b0_0_00_0_0_0_1_0_0_0_0_0_0);
        apply(16'h0000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_1_0_0_0);
        apply(16'hA000, 1'b0, 14'b1_0_10_1_0_0_0_0_0_1_0_0_0);
        // Halt again to confirm stickiness over several cycles.
        apply(16'hF123, 1'b0, 14'b0_0_00_0_0_0_1_0_0_0_0_0_0);
        apply(16'h1000, 1'b0, 14'b0_0_00_0_0_0_0_0_0_0_0_0_1);
        apply(16'hB000, 1'b0, 14'b1_0_10_1_0_0_0_0_0_0_0_0_1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
